// File: rtl/delay_pipe_sched.sv
// Round-robin scheduler sharing one fixed-latency external delay line among NREQ requesters.
// A {vld, tag} shadow pipeline, aligned with the datapath, routes each result back to its issuer.
module delay_pipe_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int LAT  = 3,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [DW-1:0]        pipe_xi,
    input  logic [DW-1:0]        pipe_xo,
    output logic [NREQ-1:0]      resp_valid,
    output logic [DW-1:0]        resp_data,
    input  logic                 drain_req,
    output logic                 drain_done,
    output logic                 busy
);

    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t          state_reg, state_next;
    logic [IDW-1:0]  ptr_reg, ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [LAT-1:0]  vld_reg;
    logic [IDW-1:0]  tag_reg [LAT];
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  scan_idx;
    logic            grant_found;
    logic            arb_en;
    logic            issue;
    logic            retire;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; DRAIN exits on the in-flight count seen at the start of the cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:   if (drain_req) state_next = ST_DRAIN;
            ST_DRAIN: if (count_reg == '0) state_next = ST_DONE;
            ST_DONE:  if (!drain_req) state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // Output logic; rst_n gating keeps the combinational grant quiet while reset is held
    always_comb begin
        arb_en     = rst_n && (state_reg == ST_RUN) && !drain_req;
        drain_done = (state_reg == ST_DONE);
    end

    // Priority search starting at ptr_reg, wrapping modulo NREQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IDW'((int'(ptr_reg) + k) % NREQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign issue   = arb_en && grant_found;
    assign retire  = vld_reg[LAT-1];
    assign pipe_xi = issue ? req_data[grant_idx*DW +: DW] : '0;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign req_ready[gi]  = issue && (grant_idx == IDW'(gi));
            assign resp_valid[gi] = retire && (tag_reg[LAT-1] == IDW'(gi));
        end
    endgenerate

    assign resp_data = pipe_xo;
    assign busy      = (count_reg != '0);

    always_comb begin
        ptr_next = ptr_reg;
        if (issue) begin
            ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({issue, retire})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg   <= '0;
            count_reg <= '0;
            vld_reg   <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_reg[k] <= '0;
            end
        end else begin
            ptr_reg    <= ptr_next;
            count_reg  <= count_next;
            vld_reg[0] <= issue;
            tag_reg[0] <= grant_idx;
            for (int k = 1; k < LAT; k++) begin
                vld_reg[k] <= vld_reg[k-1];
                tag_reg[k] <= tag_reg[k-1];
            end
        end
    end

endmodule

// File: tb/tb_delay_pipe_sched.sv
// Scoreboard bench for delay_pipe_sched: a round-robin/drain reference model predicts grants,
// queues expected responses, and an independent monitor retires them against the DUT outputs.
module tb_delay_pipe_sched;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int LAT  = 3;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [DW-1:0]       pipe_xi;
    logic [DW-1:0]       pipe_xo;
    logic [NREQ-1:0]     resp_valid;
    logic [DW-1:0]       resp_data;
    logic                drain_req;
    logic                drain_done;
    logic                busy;

    always #5 clk = ~clk;

    delay_pipe_sched #(.NREQ(NREQ), .DW(DW), .LAT(LAT), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .pipe_xi    (pipe_xi),
        .pipe_xo    (pipe_xo),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .busy       (busy)
    );

    // External delay line of depth LAT
    logic [DW-1:0] dl [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) dl[k] <= dl[k-1];
        dl[0] <= pipe_xi;
    end
    assign pipe_xo = dl[LAT-1];

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mptr = 0;
    int   mstate = 0;   // 0 run, 1 draining, 2 drained

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
        end
    endtask

    // One cycle of stimulus plus the model's prediction for that cycle
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d, input logic dr);
        int g;
        int qs;
        int idx;
        logic [NREQ-1:0] exp_ready;
        logic [DW-1:0]   exp_xi;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        drain_req = dr;
        #1;
        qs = sb.size();
        g  = -1;
        if (mstate == 0 && !dr) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (mptr + k) % NREQ;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_ready = '0;
        exp_xi    = '0;
        if (g >= 0) begin
            exp_ready = NREQ'(1) << g;
            exp_xi    = d[g*DW +: DW];
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("pipe_xi", 32'(pipe_xi), 32'(exp_xi));
        check("busy", 32'(busy), 32'(qs != 0));
        check("drain_done", 32'(drain_done), 32'(mstate == 2));
        $display("cycle %0d valid=%b drain=%b grant=%0d ready=%b xi=%h busy=%b done=%b",
                 cyc, v, dr, g, req_ready, pipe_xi, busy, drain_done);
        if (g >= 0) begin
            sb.push_back('{g, exp_xi, cyc + LAT});
            mptr = (g + 1) % NREQ;
        end
        case (mstate)
            0: if (dr) mstate = 1;
            1: if (qs == 0) mstate = 2;
            2: if (!dr) mstate = 0;
            default: mstate = 0;
        endcase
    endtask

    function automatic logic [NREQ*DW-1:0] rand_data();
        logic [NREQ*DW-1:0] d;
        for (int i = 0; i < NREQ; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    function automatic logic [NREQ*DW-1:0] inc_data();
        logic [NREQ*DW-1:0] d;
        for (int i = 0; i < NREQ; i++) d[i*DW +: DW] = DW'(8'h10 + i);
        return d;
    endfunction

    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_pipe_xi", 32'(pipe_xi), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_drain_done", 32'(drain_done), 32'(0));
    endtask

    // Monitor: retires expected responses whenever the DUT strobes resp_valid
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                check("resp_valid_in_reset", 32'(resp_valid), 32'(0));
            end else if (resp_valid != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected cycle %0d: got resp_valid=%b expected none", cyc, resp_valid);
                end else begin
                    e = sb.pop_front();
                    check("resp_valid", 32'(resp_valid), 32'(NREQ'(1) << e.id));
                    check("resp_data", 32'(resp_data), 32'(e.data));
                    check("resp_cycle", 32'(cyc), 32'(e.due));
                    $display("cycle %0d resp id=%0d data=%h", cyc, e.id, resp_data);
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL resp_missing cycle %0d: got no resp_valid expected id %0d due %0d", cyc, e.id, e.due);
            end
        end
    end

    initial begin
        logic dr;
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = inc_data();
        drain_req = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single pulse from requester 2
        step(4'b0100, {8'h00, 8'h5A, 8'h00, 8'h00}, 1'b0);
        repeat (5) step('0, '0, 1'b0);

        // All requesters continuously valid
        repeat (12) step('1, inc_data(), 1'b0);
        repeat (4) step('0, '0, 1'b0);

        // ptr lands on 2 after req 1, then 1 and 3 alternate
        step(4'b0010, rand_data(), 1'b0);
        repeat (6) step(4'b1010, rand_data(), 1'b0);
        repeat (4) step('0, '0, 1'b0);

        // Drain with three in flight
        repeat (3) step('1, rand_data(), 1'b0);
        repeat (6) step('1, rand_data(), 1'b1);
        repeat (4) step('1, rand_data(), 1'b0);
        repeat (4) step('0, '0, 1'b0);

        // Drain with an empty pipeline
        repeat (4) step('1, rand_data(), 1'b1);
        repeat (2) step('0, '0, 1'b0);

        // drain_req dropped while still draining
        repeat (3) step('1, rand_data(), 1'b0);
        step('1, rand_data(), 1'b1);
        repeat (6) step('1, rand_data(), 1'b0);
        repeat (4) step('0, '0, 1'b0);

        // Reset with two items in flight
        repeat (2) step('1, rand_data(), 1'b0);
        @(negedge clk);
        req_valid = '1;
        req_data  = rand_data();
        #1;
        rst_n = 1'b0;
        sb.delete();
        mptr   = 0;
        mstate = 0;
        #1;
        check_reset_outputs();
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(4'b0100, rand_data(), 1'b0);
        repeat (5) step('0, '0, 1'b0);

        // Randomized traffic with occasional drain episodes
        dr = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0) dr = ~dr;
            step(NREQ'($urandom), rand_data(), dr);
        end
        repeat (LAT + 4) step('0, '0, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_pipe_sched.md
Name: delay_pipe_sched

Overview:
- Shares one fixed-latency delay-line datapath among NREQ requesters.
- Round-robin arbitration picks at most one item per cycle and drives it into the pipeline.
- A requester-ID tag travels through a shadow shift register aligned with the datapath, so each result is returned to the requester that issued it.
- Drain handshake: upstream control can quiesce the pipeline, e.g. before reconfiguration.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width per item.
- LAT, 3, datapath latency in cycles; must equal the delay line's DLT (>=1).
- IDW, 2, tag width = ceil(log2(NREQ)).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  per-requester item valid
- req_data  in  NREQ*DW  requester i data at [i*DW +: DW]
- req_ready  out  NREQ  one-hot-or-zero grant; issue = req_valid[i] & req_ready[i]
- pipe_xi  out  DW  to delay line xi
- pipe_xo  in  DW  from delay line xo
- resp_valid  out  NREQ  one-hot-or-zero result strobe, 1 cycle
- resp_data  out  DW  result data (= pipe_xo)
- drain_req  in  1  level request to quiesce
- drain_done  out  1  pipeline empty, issue blocked
- busy  out  1  at least one item in flight

Behaviour:
- Reset values:
  - State=RUN, rr pointer=0, tag/valid shift stages=0, in-flight count=0.
  - Outputs: req_ready=0, resp_valid=0, drain_done=0, busy=0, pipe_xi=0.
- Arbitration (combinational, RUN state only, drain_req=0):
  - Search starts at requester index ptr and wraps modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - No valid requester: req_ready=0.
  - req_ready never depends on a requester's own valid beyond this priority search.
- Pointer update: on an issue by requester g at a clock edge, ptr <= (g+1) mod NREQ. With no issue, ptr holds.
- pipe_xi:
  - Equals req_data of the granted requester in an issue cycle; otherwise 0.
  - The delay line captures it on the same edge.
- Tag pipeline:
  - LAT stages of {vld, tag[IDW-1:0]}.
  - Stage 0 loads {issue, g} every edge; stage k loads stage k-1.
- Response:
  - resp_valid = onehot(tag[LAT-1]) when vld[LAT-1]=1, else 0.
  - resp_data = pipe_xo, unregistered.
  - Latency: issue sampled at edge t gives the response during the cycle after edge t+LAT-1 (LAT cycles after the issue cycle).
  - Back-to-back issues give back-to-back responses in issue order.
  - Responses have no backpressure.
- In-flight counter:
  - Width ceil(log2(LAT+1)); +1 on issue, -1 when vld[LAT-1]=1.
  - Simultaneous issue and retire: unchanged. Never exceeds LAT.
  - busy = (count != 0).
- FSM:
  - RUN: normal arbitration. drain_req=1 forces req_ready=0 in that same cycle; next state DRAIN.
  - DRAIN: req_ready=0; stages keep shifting and responses still retire. Next state DONE when count==0, evaluated as the value at the start of the cycle.
  - DONE: drain_done=1, req_ready=0. drain_req=0 returns to RUN (drain_done drops on that edge); otherwise stay in DONE.
  - drain_req dropped during DRAIN: still complete to DONE, then return to RUN the following cycle.
  - Drain with an empty pipeline: RUN -> DRAIN -> DONE; drain_done is high 2 cycles after drain_req rises.
- Reset mid-operation: all in-flight tags are discarded and no resp_valid appears for them. The datapath contents are don't-care because its output is masked by vld.

Test Plan:
- NREQ=4, LAT=3, only req 2 valid with data 0x5A, one-cycle pulse -> req_ready=4'b0100 that cycle, pipe_xi=0x5A; resp_valid=4'b0100 and resp_data=0x5A exactly 3 cycles later; busy high for 3 cycles.
- All 4 requesters continuously valid, data=0x10+i -> grants cycle 0,1,2,3,0,... one per cycle; responses in the same order, 3 cycles delayed, back-to-back with no gaps.
- Reqs 1 and 3 valid, ptr=2 after a prior grant of req 1 -> req 3 granted first, then req 1, then 3; req 1 never starved beyond NREQ-1 cycles.
- drain_req asserted while 3 items are in flight -> req_ready=0 immediately; 3 responses still delivered; drain_done rises the cycle after count reaches 0; drain_req dropped -> arbitration resumes next cycle.
- drain_req asserted with an empty pipeline -> drain_done high 2 cycles later; no issues while high.
- rst_n pulled low with 2 items in flight -> all outputs 0 asynchronously; no resp_valid after release; first new issue responds after LAT cycles.
